mc_ctrl: RTL and testbench

Multi-cycle MIPS control unit: the initiator side of the ALU's `ALU_operation` interface. It decodes the instruction register's opcode and funct fields and sequences fetch, decode, execute, memory and writeback over several cycles. Each cycle it drives the 3-bit ALU operation code and the datapath mux and write-enable controls. It consumes the ALU `zero` and `overflow` flags and sits between the instruction register and the shared datapath.

---
 rtl/mc_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM sequencing fetch/decode/execute/memory/writeback.
// Define OVERFLOW_TRAP_EN to enable the add/sub/addi overflow trap through the EXC state.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic [2:0] ALU_operation,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REXE = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_JMP  = 4'd9,
    S_IEXE = 4'd10,
    S_IWB  = 4'd11,
    S_EXC  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;

  state_t state_reg, state_next;
  logic   trap_pending;

  assign state = state_reg;

`ifdef OVERFLOW_TRAP_EN
  logic ovf_reg, ovf_next;

  // Only signed add/sub/addi can trap; the flag lives exactly one cycle into the writeback state.
  always_comb begin
    ovf_next = 1'b0;
    if (state_reg == S_REXE && (funct == F_ADD || funct == F_SUB))
      ovf_next = overflow;
    else if (state_reg == S_IEXE && opcode == OP_ADDI)
      ovf_next = overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_reg <= 1'b0;
    else     ovf_reg <= ovf_next;
  end

  assign trap_pending = ovf_reg;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign trap_pending    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IF;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = S_IF;
    ALU_operation = 3'b000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    pc_source     = 2'b00;
    pc_we         = 1'b0;
    ir_we         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    exc           = 1'b0;
    case (state_reg)
      S_IF: begin
        mem_read      = 1'b1;
        alu_src_b     = 2'b01;
        ALU_operation = 3'b010;
        ir_we         = mem_ready;
        pc_we         = mem_ready;
        state_next    = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b     = 2'b11;
        ALU_operation = 3'b010;
        case (opcode)
          OP_RTYPE:                                     state_next = S_REXE;
          OP_LW, OP_SW:                                 state_next = S_MADR;
          OP_BEQ, OP_BNE:                               state_next = S_BR;
          OP_J:                                         state_next = S_JMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:   state_next = S_IEXE;
          default:                                      state_next = S_IF;
        endcase
      end
      S_MADR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        ALU_operation = 3'b010;
        state_next    = (opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        state_next = mem_ready ? S_MWB : S_MRD;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_IF;
      end
      S_MWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        state_next = mem_ready ? S_IF : S_MWR;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        case (funct)
          F_ADD:   ALU_operation = 3'b010;
          F_SUB:   ALU_operation = 3'b110;
          F_AND:   ALU_operation = 3'b000;
          F_OR:    ALU_operation = 3'b001;
          F_XOR:   ALU_operation = 3'b011;
          F_NOR:   ALU_operation = 3'b100;
          F_SLT:   ALU_operation = 3'b111;
          F_SRL:   ALU_operation = 3'b101;
          default: ALU_operation = 3'b010;
        endcase
        state_next = S_RWB;
      end
      S_RWB: begin
        reg_write  = ~trap_pending;
        reg_dst    = 1'b1;
        state_next = trap_pending ? S_EXC : S_IF;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        ALU_operation = 3'b110;
        pc_source     = 2'b01;
        pc_we         = (opcode == OP_BNE) ? ~zero : zero;
        state_next    = S_IF;
      end
      S_JMP: begin
        pc_source  = 2'b10;
        pc_we      = 1'b1;
        state_next = S_IF;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: ALU_operation = 3'b000;
          OP_ORI:  ALU_operation = 3'b001;
          OP_XORI: ALU_operation = 3'b011;
          OP_SLTI: ALU_operation = 3'b111;
          default: ALU_operation = 3'b010;
        endcase
        ext_zero   = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        state_next = S_IWB;
      end
      S_IWB: begin
        reg_write  = ~trap_pending;
        state_next = trap_pending ? S_EXC : S_IF;
      end
`ifdef OVERFLOW_TRAP_EN
      S_EXC: begin
        exc        = 1'b1;
        pc_source  = 2'b11;
        pc_we      = 1'b1;
        state_next = S_IF;
      end
`endif
      default: state_next = S_IF;
    endcase
    // Reset abandons the current instruction: no architectural write may escape this cycle.
    if (rst) begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      exc       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: builds the expected per-cycle state trace of each
// instruction from its class and stall counts, then checks every control output per cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, mem_ready;
  logic [2:0] ALU_operation;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_source;
  logic       pc_we, ir_we, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, exc;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .ALU_operation(ALU_operation),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_source(pc_source), .pc_we(pc_we), .ir_we(ir_we), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .exc(exc), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] op;
    logic       a;
    logic [1:0] b;
    logic       ez;
    logic [1:0] pcs;
    logic       pc_we, ir_we, mr, mw, iord, rw, rd, m2r, exc;
  } ctl_t;

  ctl_t obs;
  assign obs = {state, ALU_operation, alu_src_a, alu_src_b, ext_zero, pc_source,
                pc_we, ir_we, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, exc};

  // ALU code the instruction set assigns to each R-type funct.
  function automatic logic [2:0] rtype_op(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      6'b000010: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] itype_op(input logic [5:0] opc);
    case (opc)
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001110: return 3'b011;
      6'b001010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input int st, input logic [5:0] opc, input logic [5:0] fn,
                                      input logic z, input logic mrdy, input logic trap);
    ctl_t c = '0;
    c.st = st[3:0];
    case (st)
      0:  begin c.mr = 1; c.b = 2'b01; c.op = 3'b010; c.ir_we = mrdy; c.pc_we = mrdy; end
      1:  begin c.b = 2'b11; c.op = 3'b010; end
      2:  begin c.a = 1; c.b = 2'b10; c.op = 3'b010; end
      3:  begin c.mr = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mw = 1; c.iord = 1; end
      6:  begin c.a = 1; c.op = rtype_op(fn); end
      7:  begin c.rw = ~trap; c.rd = 1; end
      8:  begin c.a = 1; c.op = 3'b110; c.pcs = 2'b01; c.pc_we = (opc == 6'b000101) ? ~z : z; end
      9:  begin c.pcs = 2'b10; c.pc_we = 1; end
      10: begin
            c.a = 1; c.b = 2'b10; c.op = itype_op(opc);
            c.ez = (opc == 6'b001100) || (opc == 6'b001101) || (opc == 6'b001110);
          end
      11: c.rw = ~trap;
      12: begin c.exc = 1; c.pcs = 2'b11; c.pc_we = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Runs one instruction from IF back to IF, checking every cycle plus the return to IF.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                           input logic ov, input int stall_if, input int stall_mem,
                           input string name);
    int   sq[$];
    logic rq[$];
    logic trap;
    ctl_t exp_c;
    logic is_r, is_i, is_mem, is_br;
    is_r   = (opc == 6'b000000);
    is_i   = (opc == 6'b001000) || (opc == 6'b001100) || (opc == 6'b001101) ||
             (opc == 6'b001110) || (opc == 6'b001010);
    is_mem = (opc == 6'b100011) || (opc == 6'b101011);
    is_br  = (opc == 6'b000100) || (opc == 6'b000101);
`ifdef OVERFLOW_TRAP_EN
    trap = ov && ((is_r && (fn == 6'b100000 || fn == 6'b100010)) || opc == 6'b001000);
`else
    trap = 1'b0;
`endif
    for (int k = 0; k < stall_if; k++) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(1'b1);
    sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
    if (is_r) begin
      sq.push_back(6); rq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(7); rq.push_back(1'($urandom_range(0, 1)));
      if (trap) begin sq.push_back(12); rq.push_back(1'($urandom_range(0, 1))); end
    end else if (is_i) begin
      sq.push_back(10); rq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(11); rq.push_back(1'($urandom_range(0, 1)));
      if (trap) begin sq.push_back(12); rq.push_back(1'($urandom_range(0, 1))); end
    end else if (is_mem) begin
      int ms = (opc == 6'b100011) ? 3 : 5;
      sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < stall_mem; k++) begin sq.push_back(ms); rq.push_back(1'b0); end
      sq.push_back(ms); rq.push_back(1'b1);
      if (opc == 6'b100011) begin sq.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
    end else if (is_br) begin
      sq.push_back(8); rq.push_back(1'($urandom_range(0, 1)));
    end else if (opc == 6'b000010) begin
      sq.push_back(9); rq.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      opcode = opc; funct = fn; zero = z; overflow = ov; mem_ready = rq[i];
      #1;
      exp_c = expect_ctl(sq[i], opc, fn, z, rq[i], trap);
      n_tests++;
      if (obs !== exp_c) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got ctl=%h (state %0d), expected ctl=%h (state %0d)",
                 name, i, obs, state, exp_c, sq[i]);
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL %s end: got state %0d, expected 0 after %0d cycles", name, state, sq.size());
    end
    $display("[TB] %s opcode=%b funct=%b zero=%b ovf=%b cycles=%0d", name, opc, fn, z, ov, sq.size());
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b100011; funct = '0; zero = 0; overflow = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", state); end
    n_tests++;
    if ({pc_we, ir_we, mem_write, reg_write, exc} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_writes: got %b, expected 00000", {pc_we, ir_we, mem_write, reg_write, exc});
    end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_rtype();
    logic [5:0] fns [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b101010, 6'b000010, 6'b111111};
    run_instr(6'b000000, 6'b100000, 0, 0, 0, 0, "add_plain");
    foreach (fns[i]) run_instr(6'b000000, fns[i], 1'($urandom_range(0, 1)), 0,
                               $urandom_range(0, 2), 0, "rtype");
  endtask

  task automatic test_itype();
    logic [5:0] ops [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
    foreach (ops[i]) run_instr(ops[i], 6'($urandom), 0, 0, $urandom_range(0, 2), 0, "itype");
  endtask

  task automatic test_mem();
    run_instr(6'b100011, 6'b0, 0, 0, 0, 2, "lw_stall2");
    run_instr(6'b100011, 6'b0, 0, 0, 0, 0, "lw");
    run_instr(6'b101011, 6'b0, 0, 0, 1, 3, "sw_stall");
    run_instr(6'b101011, 6'b0, 0, 0, 0, 0, "sw");
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'b0, 1, 0, 0, 0, "beq_taken");
    run_instr(6'b000100, 6'b0, 0, 0, 0, 0, "beq_not_taken");
    run_instr(6'b000101, 6'b0, 0, 0, 0, 0, "bne_taken");
    run_instr(6'b000101, 6'b0, 1, 0, 0, 0, "bne_not_taken");
    run_instr(6'b000010, 6'b0, 0, 0, 1, 0, "jump");
    run_instr(6'b111111, 6'b0, 0, 0, 0, 0, "illegal_op");
  endtask

  task automatic test_overflow();
    run_instr(6'b001000, 6'b0, 0, 1, 0, 0, "addi_ovf");
    run_instr(6'b000000, 6'b100000, 0, 1, 0, 0, "add_ovf");
    run_instr(6'b000000, 6'b100010, 0, 1, 0, 0, "sub_ovf");
    run_instr(6'b000000, 6'b100100, 0, 1, 0, 0, "and_ovf_notrap");
    run_instr(6'b001101, 6'b0, 0, 1, 0, 0, "ori_ovf_notrap");
    run_instr(6'b000000, 6'b100000, 0, 0, 0, 0, "add_after_trap");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); opcode = 6'b101011; mem_ready = 1'b1;   // IF
    @(negedge clk);                                          // ID
    @(negedge clk);                                          // MADR
    @(negedge clk); mem_ready = 1'b0;                        // MWR, waiting
    @(negedge clk); rst = 1'b1;                              // still MWR, reset arrives
    #1;
    n_tests++;
    if (state !== 4'd5) begin n_fail++; $display("FAIL rst_mid_state_before: got %0d, expected 5", state); end
    n_tests++;
    if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_write: got %b, expected 0", mem_write); end
    @(negedge clk); rst = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL rst_mid_state_after: got %0d, expected 0", state); end
    $display("[TB] reset during sw wait checked");
  endtask

  task automatic test_random();
    logic [5:0] ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                             6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b010001};
    logic [5:0] fns [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b101010, 6'b000010};
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 7)],
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_mem();
    test_branch();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
